// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache (port 0) and
// D-cache (port 1); serialises block reads/writes and absorbs the fixed read latency.
module mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            req0,
   input  logic            req1,
   input  logic            we0,
   input  logic            we1,
   input  logic [31:0]     addr0,
   input  logic [31:0]     addr1,
   input  logic [0:3][7:0] wdata0,
   input  logic [0:3][7:0] wdata1,
   output logic [0:3][7:0] rdata0,
   output logic [0:3][7:0] rdata1,
   output logic            done0,
   output logic            done1,
   output logic            busy,
   output logic            grant,
   output logic [31:0]     mem_addr,
   output logic            mem_write_en,
   output logic [0:3][7:0] mem_data_in,
   input  logic [0:3][7:0] mem_data_out
);

   localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

   state_t          state;
   logic            last;
   logic            sel;
   logic            we_q;
   logic [CntW-1:0] cnt;
   logic            pick;

   // On a tie, serve the port that did not win the previous tie.
   always_comb begin
      if (req0 && req1) pick = ~last;
      else              pick = req1;
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state        <= StIdle;
         last         <= 1'b1;
         sel          <= 1'b0;
         we_q         <= 1'b0;
         cnt          <= '0;
         rdata0       <= '0;
         rdata1       <= '0;
         done0        <= 1'b0;
         done1        <= 1'b0;
         busy         <= 1'b0;
         grant        <= 1'b0;
         mem_addr     <= '0;
         mem_write_en <= 1'b0;
         mem_data_in  <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               mem_write_en <= 1'b0;
               if (req0 || req1) begin
                  if (req0 && req1) last <= pick;
                  sel          <= pick;
                  grant        <= pick;
                  we_q         <= pick ? we1 : we0;
                  mem_addr     <= pick ? addr1 : addr0;
                  mem_data_in  <= pick ? wdata1 : wdata0;
                  mem_write_en <= pick ? we1 : we0;
                  cnt          <= '0;
                  busy         <= 1'b1;
                  state        <= StAccess;
               end
            end
            StAccess: begin
               if (we_q) begin
                  // Memory commits the write on this edge.
                  mem_write_en <= 1'b0;
                  done0        <= ~sel;
                  done1        <= sel;
                  state        <= StDone;
               end else begin
                  cnt <= cnt + CntW'(1);
                  if (cnt == CntW'(MEM_LATENCY - 1)) begin
                     if (sel) rdata1 <= mem_data_out;
                     else     rdata0 <= mem_data_out;
                     done0 <= ~sel;
                     done1 <= sel;
                     state <= StDone;
                  end
               end
            end
            StDone: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked cycle-by-cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int unsigned L = 4;

   logic            clk = 1'b0;
   logic            rst_b = 1'b0;
   logic            req0, req1, we0, we1;
   logic [31:0]     addr0, addr1;
   logic [0:3][7:0] wdata0, wdata1, rdata0, rdata1;
   logic            done0, done1, busy, grant;
   logic [31:0]     mem_addr;
   logic            mem_write_en;
   logic [0:3][7:0] mem_data_in, mem_data_out;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LATENCY(L)) dut (
      .clk(clk), .rst_b(rst_b),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
      .busy(busy), .grant(grant),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   // Requesters
   logic [1:0]  r_req = '0;
   logic [1:0]  r_we = '0;
   logic [31:0] r_addr [2];
   logic [31:0] r_wdata [2];
   assign req0 = r_req[0];
   assign req1 = r_req[1];
   assign we0 = r_we[0];
   assign we1 = r_we[1];
   assign addr0 = r_addr[0];
   assign addr1 = r_addr[1];
   assign wdata0 = r_wdata[0];
   assign wdata1 = r_wdata[1];

   // Memory: data is valid only once the address has been stable for L cycles.
   logic [31:0] env_mem [16];
   logic [31:0] addr_prev = '0;
   int          age_q = 0;
   int          age;
   always_comb age = (mem_addr == addr_prev) ? age_q + 1 : 1;
   assign mem_data_out = (age >= int'(L)) ? env_mem[mem_addr[3:0]] : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      addr_prev <= mem_addr;
      age_q     <= (age < 1000) ? age : age_q;
      if (mem_write_en) env_mem[mem_addr[3:0]] <= mem_data_in;
   end

   // Transaction-level reference model
   logic [31:0] ref_mem [16];
   int          cyc = 0;
   int          idle_from = 0;
   logic        m_last = 1'b1;
   logic        t_act = 1'b0;
   logic        t_port, t_we;
   int          t_g, t_d;
   logic [31:0] t_addr, t_wdata;
   logic        e_grant = 1'b0;
   logic [31:0] e_maddr = '0, e_mdin = '0;
   logic [31:0] e_rdata [2];
   logic [1:0]  pending = '0, done_flag = '0;
   int          seq = 100;
   int          n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      t_act = 1'b0; idle_from = cyc; m_last = 1'b1;
      e_grant = 1'b0; e_maddr = '0; e_mdin = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      r_req = '0; pending = '0; done_flag = '0;
   endtask

   // One clock cycle: check outputs of cycle cyc, retire/arbitrate, advance past the edge.
   task automatic step();
      @(negedge clk);
      if (t_act && cyc == t_g) begin
         e_grant = t_port; e_maddr = t_addr; e_mdin = t_wdata;
      end
      if (t_act && cyc == t_d) begin
         if (t_we) ref_mem[t_addr[3:0]] = t_wdata;
         else      e_rdata[t_port] = ref_mem[t_addr[3:0]];
      end
      check("done0", done0, t_act && cyc == t_d && !t_port);
      check("done1", done1, t_act && cyc == t_d && t_port);
      check("busy", busy, t_act && cyc >= t_g);
      check("mem_write_en", mem_write_en, t_act && t_we && cyc == t_g);
      check("grant", grant, e_grant);
      check("mem_addr", mem_addr, e_maddr);
      check("mem_data_in", mem_data_in, e_mdin);
      check("rdata0", rdata0, e_rdata[0]);
      check("rdata1", rdata1, e_rdata[1]);
      if (t_act && cyc == t_d) begin
         t_act = 1'b0;
         idle_from = t_d + 1;
         done_flag[t_port] = 1'b1;
      end
      if (!t_act && cyc >= idle_from && (r_req != 2'b00)) begin
         t_port = (r_req == 2'b11) ? ~m_last : r_req[1];
         if (r_req == 2'b11) m_last = t_port;
         t_act = 1'b1;
         t_we = r_we[t_port];
         t_addr = r_addr[t_port];
         t_wdata = r_wdata[t_port];
         t_g = cyc + 1;
         t_d = t_we ? cyc + 2 : cyc + 1 + int'(L);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      r_we[p] = we; r_addr[p] = a; r_wdata[p] = d;
      r_req[p] = 1'b1; pending[p] = 1'b1; done_flag[p] = 1'b0;
   endtask

   task automatic issue_rand(input int p);
      seq++;
      issue(p, 1'($urandom), {seq[19:0], 8'h00, 4'($urandom)}, $urandom);
   endtask

   // Run until every outstanding transaction has completed; requests drop on completion.
   task automatic drain();
      for (int i = 0; i < 200 && pending != 2'b00; i++) begin
         step();
         for (int p = 0; p < 2; p++) begin
            if (done_flag[p]) begin
               done_flag[p] = 1'b0; pending[p] = 1'b0; r_req[p] = 1'b0;
            end
         end
      end
      check("drain_timeout", {30'd0, pending}, 32'd0);
   endtask

   task automatic rand_phase(input int ncyc, input int pct);
      for (int n = 0; n < ncyc; n++) begin
         step();
         for (int p = 0; p < 2; p++) begin
            if (done_flag[p]) begin
               done_flag[p] = 1'b0; pending[p] = 1'b0;
               if (int'($urandom_range(99)) < pct) issue_rand(p);
               else r_req[p] = 1'b0;
            end else if (!pending[p]) begin
               if (int'($urandom_range(99)) < pct) issue_rand(p);
            end else if (t_act && t_port == 1'(p) && cyc > t_g && $urandom_range(99) < 5) begin
               r_req[p] = 1'b0;
            end
         end
      end
      drain();
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      env_mem[0] = 32'h1122_3344;
      ref_mem[0] = 32'h1122_3344;
      r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      #1 rst_b = 1'b1;
      step();
      step();
      rst_b = 1'b0;

      // Single read port 0, single write port 1, then simultaneous requests.
      issue(0, 1'b0, 32'h0000_0040, 32'h0);
      drain();
      issue(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
      drain();
      issue(0, 1'b0, 32'h0000_0203, 32'h0);
      issue(1, 1'b0, 32'h0000_0305, 32'h0);
      drain();

      // Read on port 1 with its request dropped in cycle 2.
      issue(1, 1'b0, 32'h0000_0417, 32'h0);
      step();
      step();
      r_req[1] = 1'b0;
      drain();

      // Reset asserted in cycle 3 of a read.
      issue(0, 1'b0, 32'h0000_0529, 32'h0);
      step();
      step();
      step();
      #2 rst_b = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_we", mem_write_en, 0);
      check("rst_done", {done1, done0}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_grant", grant, 0);
      model_reset();
      step();
      step();
      rst_b = 1'b0;
      issue(0, 1'b0, 32'h0000_0640, 32'h0);
      drain();

      // Both ports held continuously, then mixed random traffic.
      rand_phase(300, 100);
      rand_phase(1500, 40);
      rand_phase(500, 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
